// File: rtl/fifo_controller_pkg.sv
// Shared definitions for the FIFO controller slice: default parameter
// values, depth/count-width derivations and the status-flag bundle.
package fifo_controller_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 32'sd6;
  localparam int DEFAULT_ADDR_WIDTH   = 32'sd3;
  localparam int DEFAULT_ALMOST_FULL  = 32'sd6;
  localparam int DEFAULT_ALMOST_EMPTY = 32'sd2;

  // Number of words the memory holds for a given address width.
  function automatic int depthOf(input int addrWidth);
    return 32'sd1 << addrWidth;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int countWidthOf(input int addrWidth);
    return addrWidth + 32'sd1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almostFull;
    logic almostEmpty;
  } fifoStatus_t;

endpackage

// File: rtl/fifo_controller_chk.sv
// Simulation-only sanity checks for the FIFO controller: legal threshold
// parameters and occupancy never exceeding the memory depth.
module fifo_controller_chk #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input logic                Clock,
  input logic [ADDR_WIDTH:0] iCount
);

  localparam int DEPTH = 32'sd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  // Parameter legality and occupancy bound, re-evaluated every cycle.
  always_ff @(posedge Clock) begin
    assert (DATA_WIDTH > 32'sd0 && ALMOST_EMPTY >= 32'sd0 &&
            ALMOST_EMPTY < ALMOST_FULL && ALMOST_FULL <= DEPTH)
      else $error("fifo_controller: illegal parameter set");
    assert (iCount <= COUNT_DEPTH)
      else $error("fifo_controller: occupancy beyond depth");
  end

endmodule

// File: rtl/fifo_ptr.sv
// Wrapping address pointer: clears on Reset, advances by one when enabled,
// and rolls over from the last address back to zero naturally.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iIncrement,
  output logic [ADDR_WIDTH-1:0] oPointer
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Pointer register; modulo-DEPTH wrap comes from the fixed register width.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oPointer <= PTR_ZERO;
    end else if (iIncrement) begin
      oPointer <= oPointer + PTR_ONE;
    end else begin
      oPointer <= oPointer;
    end
  end

endmodule

// File: rtl/fifo_controller.sv
// Sequencing controller that turns a dual-port memory into a synchronous
// FIFO. Owns pointers, occupancy, status and sticky error flags; the data
// path itself lives entirely in the memory.
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL  = DEFAULT_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEFAULT_ALMOST_EMPTY
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  output logic                  oMemWriteEnable,
  output logic [ADDR_WIDTH-1:0] oMemWriteAddress,
  output logic                  oMemReadEnable,
  output logic [ADDR_WIDTH-1:0] oMemReadAddress,
  output logic                  oDataValid,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int DEPTH       = depthOf(ADDR_WIDTH);
  localparam int COUNT_WIDTH = countWidthOf(ADDR_WIDTH);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO  = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_DEPTH = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AF_LEVEL    = COUNT_WIDTH'(ALMOST_FULL);
  localparam logic [COUNT_WIDTH-1:0] AE_LEVEL    = COUNT_WIDTH'(ALMOST_EMPTY);

  logic [COUNT_WIDTH-1:0] countR;
  logic                   dataValidR;
  logic                   overflowR;
  logic                   underflowR;
  logic                   pushOk;
  logic                   popOk;
  logic [ADDR_WIDTH-1:0]  wrPtr;
  logic [ADDR_WIDTH-1:0]  rdPtr;
  fifoStatus_t            status;

  // Status decode from the registered count, then request acceptance.
  // Gating on full/empty keeps a simultaneous push+pop at either boundary
  // from ever touching the same address.
  always_comb begin
    status.full        = (countR == COUNT_DEPTH);
    status.empty       = (countR == COUNT_ZERO);
    status.almostFull  = (countR >= AF_LEVEL);
    status.almostEmpty = (countR <= AE_LEVEL);
    pushOk             = iPush & ~status.full;
    popOk              = iPop & ~status.empty;
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) uWritePtr (
    .Clock      (Clock),
    .Reset      (Reset),
    .iIncrement (pushOk),
    .oPointer   (wrPtr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) uReadPtr (
    .Clock      (Clock),
    .Reset      (Reset),
    .iIncrement (popOk),
    .oPointer   (rdPtr)
  );

  // Occupancy tracks accepted pushes minus accepted pops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      countR <= COUNT_ZERO;
    end else begin
      case ({pushOk, popOk})
        2'b10:   countR <= countR + COUNT_ONE;
        2'b01:   countR <= countR - COUNT_ONE;
        default: countR <= countR;
      endcase
    end
  end

  // Read data valid one cycle after an accepted pop; sticky error capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dataValidR <= 1'b0;
      overflowR  <= 1'b0;
      underflowR <= 1'b0;
    end else begin
      dataValidR <= popOk;
      overflowR  <= overflowR | (iPush & status.full);
      underflowR <= underflowR | (iPop & status.empty);
    end
  end

  assign oMemWriteEnable  = pushOk;
  assign oMemWriteAddress = wrPtr;
  assign oMemReadEnable   = popOk;
  assign oMemReadAddress  = rdPtr;
  assign oDataValid       = dataValidR;
  assign oCount           = countR;
  assign oFull            = status.full;
  assign oEmpty           = status.empty;
  assign oAlmostFull      = status.almostFull;
  assign oAlmostEmpty     = status.almostEmpty;
  assign oOverflow        = overflowR;
  assign oUnderflow       = underflowR;

  fifo_controller_chk #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  ) uChk (
    .Clock  (Clock),
    .iCount (countR)
  );

endmodule

// File: doc/fifo_controller.md
Name: fifo_controller

Overview:
- Sequencing controller that turns the dual-port memory into a synchronous FIFO.
- Owns the write/read pointers, occupancy count, status flags and error flags.
- Drives the memory's write-enable/address and read-enable/address ports.
- Producer data goes straight to the memory's iDataIn; consumer takes the memory's oDataOut, qualified by oDataValid.

Parameters:
- DATA_WIDTH, 6, memory word width; documentation only, no datapath inside this block.
- ADDR_WIDTH, 3, memory address width; FIFO depth DEPTH = 2**ADDR_WIDTH (8).
- ALMOST_FULL, 6, oAlmostFull asserted when count >= ALMOST_FULL.
- ALMOST_EMPTY, 2, oAlmostEmpty asserted when count <= ALMOST_EMPTY.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- iPush  input  1  producer write request; data presented on memory iDataIn in the same cycle.
- iPop  input  1  consumer read request.
- oMemWriteEnable  output  1  to memory iWriteEnable.
- oMemWriteAddress  output  ADDR_WIDTH  to memory iWriteAddress.
- oMemReadEnable  output  1  to memory iReadEnable.
- oMemReadAddress  output  ADDR_WIDTH  to memory iReadAddress.
- oDataValid  output  1  memory oDataOut holds popped word.
- oCount  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- oFull  output  1  count == DEPTH.
- oEmpty  output  1  count == 0.
- oAlmostFull  output  1  count >= ALMOST_FULL.
- oAlmostEmpty  output  1  count <= ALMOST_EMPTY.
- oOverflow  output  1  sticky: push attempted while full.
- oUnderflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset is sampled on the rising Clock edge. It clears wr_ptr, rd_ptr, count, oDataValid, oOverflow and oUnderflow to 0.
- After reset: oEmpty=1, oAlmostEmpty=1, oFull=0, oAlmostFull=0. Memory contents are not cleared.
- Reset mid-operation discards all queued words. oDataValid drops at that same edge, and no in-flight pop is reported.
- Accept rules (combinational, from registered count):
  - push_ok = iPush & ~oFull.
  - pop_ok = iPop & ~oEmpty.
- Memory drive (combinational):
  - oMemWriteEnable = push_ok; oMemWriteAddress = wr_ptr.
  - oMemReadEnable = pop_ok; oMemReadAddress = rd_ptr.
- Per edge:
  - wr_ptr += push_ok and rd_ptr += pop_ok, both modulo DEPTH (natural wrap DEPTH-1 -> 0).
  - count += push_ok - pop_ok.
  - Flags are registered-derived from count and update in the cycle after the edge.
- Read latency is 1: oDataValid is registered pop_ok. The word is on memory oDataOut while oDataValid=1.
- Simultaneous push and pop:
  - Mid-range: both accepted, count unchanged, pointers both advance.
  - Empty: only the push is accepted; pop rejected and oUnderflow set. No read-during-write on the same address.
  - Full: only the pop is accepted; push rejected and oOverflow set. No same-address collision.
- oOverflow and oUnderflow stay set until Reset.
- Rejected requests change nothing except the sticky flags.
- Back-to-back pops sustain one word per cycle. oDataValid stays high on consecutive cycles.
- Width rules:
  - count is ADDR_WIDTH+1 bits and never exceeds DEPTH or underflows below 0.
  - Pointers are ADDR_WIDTH bits.
- Legal parameter range: 0 <= ALMOST_EMPTY < ALMOST_FULL <= DEPTH. Enforce it with a simulation-time check.

Decomposition:
- Shared header include `fifo_defs.vh` holds:
  - DEPTH localparam derivation.
  - Default ALMOST_FULL/ALMOST_EMPTY values.
  - COUNT_WIDTH = ADDR_WIDTH+1.
- One natural sub-module: `fifo_ptr`, a wrapping ADDR_WIDTH-bit pointer with synchronous Reset and increment enable. Instantiate it twice (write and read).
- count and flags stay in the top module.

Test Plan:
- Reset, then idle 3 cycles -> oEmpty=1, oAlmostEmpty=1, oCount=0, oDataValid=0, both enables 0, error flags 0.
- Push 8 words 0x01..0x08 on consecutive cycles -> write addresses 0..7. Then:
  - oAlmostFull rises after the 6th push.
  - oFull=1 and oCount=8 after the 8th.
  - A 9th push gives oMemWriteEnable=0 and oOverflow=1, with count still 8.
- From full, pop 8 consecutive cycles -> read addresses 0..7, oDataValid high 8 cycles, data 0x01..0x08 in order.
  - oEmpty=1 after the last pop.
  - An extra pop gives oUnderflow=1, oMemReadEnable=0.
- Wrap test: push 5, pop 5, push 6, pop 6 -> the second batch writes addresses 5,6,7,0,1,2. Data reads back in order with no loss.
- Simultaneous push+pop at count=4 for 10 cycles -> oCount stays 4, oDataValid every cycle, FIFO order preserved.
  - Push+pop at empty: only the push is accepted (count 1, oUnderflow=1).
  - Push+pop at full: only the pop is accepted (count 7, oOverflow=1).
- Reset asserted with count=5 and a pop in flight -> next cycle oCount=0, oDataValid=0, flags cleared.
  - A subsequent push/pop uses address 0.
